// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a synchronous FIFO and the UART drain that empties it.
interface fifo_uart_tx_if;

    // Handshake: the drain may raise fifo_rd_en only while fifo_empty is low; each high
    // cycle pops one byte, and the FIFO presents that byte on fifo_data one cycle later.
    // The read data carries no backpressure.
    logic       fifo_rd_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data
    );

endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a synchronous FIFO and sends 8-bit frames
// (start bit, LSB-first data, optional parity bit, stop bit) on a registered tx line.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tx_en,
    fifo_uart_tx_if.master  fifo,
    output logic            tx,
    output logic            busy,
    output logic            frame_done,
    output logic [2:0]      state_dbg
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          parity_bit, parity_nxt;
    logic          tx_nxt;
    logic          bit_end;

    assign bit_end         = (baud_cnt == BAUD_LAST);
    assign fifo.fifo_rd_en = (state == S_IDLE) & tx_en & ~fifo.fifo_empty;
    assign busy            = (state != S_IDLE);
    assign frame_done      = (state == S_STOP) & bit_end;
    assign state_dbg       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= bit_nxt;
            shift_reg  <= shift_nxt;
            parity_bit <= parity_nxt;
            tx         <= tx_nxt;
        end
    end

    // tx is loaded one cycle ahead of each bit so it only moves on bit boundaries.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_idx;
        shift_nxt  = shift_reg;
        parity_nxt = parity_bit;
        tx_nxt     = tx;

        unique case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (fifo.fifo_rd_en) begin
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                shift_nxt  = fifo.fifo_data;
                parity_nxt = (^fifo.fifo_data) ^ PARITY_ODD;
                baud_nxt   = '0;
                bit_nxt    = '0;
                tx_nxt     = 1'b0;
                state_nxt  = S_START;
            end

            S_START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    tx_nxt    = shift_reg[0];
                    shift_nxt = shift_reg >> 1;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN) begin
                            tx_nxt    = parity_bit;
                            state_nxt = S_PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = S_STOP;
                        end
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        tx_nxt    = shift_reg[0];
                        shift_nxt = shift_reg >> 1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    tx_nxt    = 1'b1;
                    state_nxt = S_STOP;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end

            S_STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // A pop can only happen from IDLE, so it can never overlap the stop bit's last cycle.
    a_pop_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        fifo.fifo_rd_en |-> (state == S_IDLE));
    a_done_not_pop: assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_done && fifo.fifo_rd_en));

endmodule
